// File: rtl/muldiv_issue_ctrl_pkg.sv
// ============================================================================
// Module : muldiv_issue_ctrl_pkg
// Brief  : Calculator operation codes and issue-controller state encoding.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_issue_ctrl_pkg;

    localparam logic [1:0] CAL_MULTU = 2'd0;
    localparam logic [1:0] CAL_MULT  = 2'd1;
    localparam logic [1:0] CAL_DIVU  = 2'd2;
    localparam logic [1:0] CAL_DIV   = 2'd3;

    typedef enum logic [1:0] {
        MD_IDLE    = 2'd0,
        MD_ISSUE   = 2'd1,
        MD_WB      = 2'd2,
        MD_RELEASE = 2'd3
    } md_state_e;

    // A pending request stalls even while idle/releasing so EX holds the instruction.
    function automatic logic md_stall(input md_state_e s, input logic req);
        return (s == MD_ISSUE) || (s == MD_WB) || req;
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_issue_ctrl_hilo_reg.sv
// ============================================================================
// Module : muldiv_issue_ctrl_hilo_reg
// Brief  : Architectural HI/LO registers; write data is calculator result or MTHI/MTLO data.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_issue_ctrl_hilo_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_hi,
    input  logic             we_lo,
    input  logic             sel_calc,
    input  logic [WIDTH-1:0] calc_hi,
    input  logic [WIDTH-1:0] calc_lo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] w_hi_d;
    logic [WIDTH-1:0] w_lo_d;

    assign w_hi_d = sel_calc ? calc_hi : wdata;
    assign w_lo_d = sel_calc ? calc_lo : wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else begin
            if (we_hi) hi <= w_hi_d;
            if (we_lo) lo <= w_lo_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/muldiv_issue_ctrl.sv
// ============================================================================
// Module : muldiv_issue_ctrl
// Brief  : Issues MULT/DIV to the HI/LO calculator, stalls the pipe, commits HI/LO.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_issue_ctrl
    import muldiv_issue_ctrl_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             md_req,
    input  logic [1:0]       md_calc,
    input  logic [WIDTH-1:0] md_a,
    input  logic [WIDTH-1:0] md_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             stall,
    output logic             md_err,
    output logic             calc_ena,
    output logic [1:0]       calc_sel,
    output logic [WIDTH-1:0] calc_a,
    output logic [WIDTH-1:0] calc_b,
    input  logic [WIDTH-1:0] calc_lo,
    input  logic [WIDTH-1:0] calc_hi,
    input  logic             calc_finish
);

    localparam int          CNT_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned C_TLAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(C_TLAST);

    md_state_e        r_state;
    md_state_e        w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_first;
    logic             w_timeout;
    logic             w_timeout_hit;
    logic             w_mt_ok;
    logic             w_we_hi;
    logic             w_we_lo;
    logic             w_sel_calc;

    // r_cnt counts ISSUE cycles; zero marks the first cycle, where a stale finish is ignored.
    assign w_first   = (r_cnt == '0);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == C_CNT_LAST);

    always_comb begin
        w_next        = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (md_req) w_next = MD_ISSUE;
            end
            MD_ISSUE: begin
                if (!w_first && calc_finish) begin
                    w_next = MD_WB;
                end else if (w_timeout) begin
                    w_next        = MD_RELEASE;
                    w_timeout_hit = 1'b1;
                end
            end
            MD_WB: begin
                w_next = MD_RELEASE;
            end
            MD_RELEASE: begin
                if (!calc_finish) w_next = MD_IDLE;
            end
            default: begin
                w_next = MD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= MD_IDLE;
            r_cnt    <= '0;
            md_err   <= 1'b0;
            calc_sel <= '0;
            calc_a   <= '0;
            calc_b   <= '0;
        end else begin
            r_state <= w_next;
            md_err  <= w_timeout_hit;
            if (r_state != MD_ISSUE) begin
                r_cnt <= '0;
            end else if (r_cnt != '1) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_state == MD_IDLE && md_req) begin
                calc_sel <= md_calc;
                calc_a   <= md_a;
                calc_b   <= md_b;
            end
        end
    end

    assign calc_ena = (r_state == MD_ISSUE);
    assign stall    = md_stall(r_state, md_req);

    // A mul/div request takes priority over a coincident MTHI/MTLO.
    assign w_mt_ok    = (r_state == MD_IDLE) && !md_req;
    assign w_sel_calc = (r_state == MD_WB);
    assign w_we_hi    = w_sel_calc || (w_mt_ok && mthi);
    assign w_we_lo    = w_sel_calc || (w_mt_ok && mtlo);

    muldiv_issue_ctrl_hilo_reg #(
        .WIDTH (WIDTH)
    ) u_hilo (
        .clk      (clk),
        .reset    (reset),
        .we_hi    (w_we_hi),
        .we_lo    (w_we_lo),
        .sel_calc (w_sel_calc),
        .calc_hi  (calc_hi),
        .calc_lo  (calc_lo),
        .wdata    (wdata),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

`default_nettype wire

// File: tb/tb_muldiv_issue_ctrl.sv
// ============================================================================
// Module : tb_muldiv_issue_ctrl
// Brief  : Directed bench with stub calculator and commit scoreboard.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_issue_ctrl;
    import muldiv_issue_ctrl_pkg::*;

    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        md_req;
    logic [1:0]  md_calc;
    logic [31:0] md_a, md_b;
    logic        mthi, mtlo;
    logic [31:0] wdata;
    logic [31:0] hi, lo;
    logic        stall, md_err, calc_ena;
    logic [1:0]  calc_sel;
    logic [31:0] calc_a, calc_b;
    logic [31:0] calc_lo, calc_hi;
    logic        calc_finish;
    bit          stub_hang;
    int          stub_cnt;

    typedef struct {
        bit          err;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    muldiv_issue_ctrl #(
        .WIDTH          (WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .md_req      (md_req),
        .md_calc     (md_calc),
        .md_a        (md_a),
        .md_b        (md_b),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .hi          (hi),
        .lo          (lo),
        .stall       (stall),
        .md_err      (md_err),
        .calc_ena    (calc_ena),
        .calc_sel    (calc_sel),
        .calc_a      (calc_a),
        .calc_b      (calc_b),
        .calc_lo     (calc_lo),
        .calc_hi     (calc_hi),
        .calc_finish (calc_finish)
    );

    function automatic logic [63:0] calc_model(input logic [1:0] s, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sp;
        logic signed [31:0] q, r;
        case (s)
            CAL_MULTU: return {32'b0, a} * {32'b0, b};
            CAL_MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                return sp;
            end
            CAL_DIVU: return {a % b, a / b};
            default: begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
        endcase
    endfunction

    // Stub calculator: finish after LAT busy cycles, held until ena drops.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            calc_finish <= 1'b0;
            stub_cnt    <= 0;
            calc_hi     <= '0;
            calc_lo     <= '0;
        end else if (!calc_ena) begin
            calc_finish <= 1'b0;
            stub_cnt    <= 0;
        end else if (!calc_finish && !stub_hang) begin
            if (stub_cnt == LAT) begin
                calc_finish        <= 1'b1;
                {calc_hi, calc_lo} <= calc_model(calc_sel, calc_a, calc_b);
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: end of calc_ena marks WB (or timeout); hi/lo are checked one cycle later.
    initial begin : monitor
        bit   prev_ena;
        bit   pend;
        exp_t cur;
        prev_ena = 1'b0;
        pend     = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_ena = 1'b0;
                pend     = 1'b0;
            end else begin
                if (pend) begin
                    chk("commit_hi", hi, cur.hi);
                    chk("commit_lo", lo, cur.lo);
                    pend = 1'b0;
                end
                if (prev_ena && !calc_ena) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_op_end", 0, 1);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("md_err_at_end", md_err, cur.err);
                        pend = 1'b1;
                    end
                end
                prev_ena = calc_ena;
            end
        end
    end

    task automatic run_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input bit err, input bit keep, input bit b2b);
        int n;
        bit stable;
        bit gap_stall;
        md_calc = c;
        md_a    = a;
        md_b    = b;
        md_req  = 1'b1;
        exp_q.push_back('{err, ehi, elo});
        #1;
        chk("stall_on_req", stall, 1);
        n = 0;
        gap_stall = 1'b1;
        while (!calc_ena && n < 20) begin
            if (!stall) gap_stall = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("ena_rise", calc_ena, 1);
        if (b2b) chk("b2b_stall_in_gap", gap_stall, 1);
        chk("calc_sel", calc_sel, c);
        chk("calc_a", calc_a, a);
        chk("calc_b", calc_b, b);
        n = 0;
        stable = 1'b1;
        while (calc_ena && n < 200) begin
            if (calc_a !== a || calc_b !== b || calc_sel !== c || !stall) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        chk("issue_stable_stalled", stable, 1);
        if (err) begin
            chk("timeout_issue_cycles", n, TIMEOUT);
            @(negedge clk);
            chk("md_err_one_cycle", md_err, 0);
        end
        if (!keep) begin
            md_req = 1'b0;
            mthi   = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin : stim
        int n;
        reset     = 1'b1;
        md_req    = 1'b0;
        md_calc   = '0;
        md_a      = '0;
        md_b      = '0;
        mthi      = 1'b0;
        mtlo      = 1'b0;
        wdata     = '0;
        stub_hang = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ena", calc_ena, 0);
        chk("rst_err", md_err, 0);
        chk("rst_calc_a", calc_a, 0);
        chk("rst_calc_sel", calc_sel, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run_op(CAL_MULT,  32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0);
        run_op(CAL_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 0, 0, 0);
        run_op(CAL_DIVU,  32'd7,        32'd2, 32'd1,        32'd3,        0, 0, 0);
        run_op(CAL_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0, 0);
        run_op(CAL_MULTU, 32'h00010000, 32'h00010000, 32'd1, 32'd0,        0, 1, 0);
        run_op(CAL_DIVU,  32'd100,      32'd7, 32'd2,        32'd14,       0, 0, 1);

        mthi  = 1'b1;
        wdata = 32'h12345678;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo_kept", lo, 32'd14);
        mtlo  = 1'b1;
        wdata = 32'h9ABCDEF0;
        @(negedge clk);
        mtlo = 1'b0;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi_kept", hi, 32'h12345678);

        // Calculator never finishes; MTHI held throughout must be ignored.
        stub_hang = 1'b1;
        mthi      = 1'b1;
        wdata     = 32'hDEADBEEF;
        run_op(CAL_MULT, 32'd9, 32'd9, 32'h12345678, 32'h9ABCDEF0, 1, 0, 0);
        stub_hang = 1'b0;
        chk("timeout_idle_stall", stall, 0);

        md_calc = CAL_MULT;
        md_a    = 32'd5;
        md_b    = 32'd5;
        md_req  = 1'b1;
        n = 0;
        while (!calc_ena && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        md_req = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midop_rst_hi", hi, 0);
        chk("midop_rst_lo", lo, 0);
        chk("midop_rst_ena", calc_ena, 0);
        chk("midop_rst_stall", stall, 0);
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);

        run_op(CAL_MULT, 32'd3, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4, 0, 0, 0);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
